// File: rtl/amax10_qsys_sd_ram_loader.sv
// Packs a little-endian byte stream into 32-bit words and writes them to
// consecutive RAM word addresses (wrapping at DEPTH) starting at a commanded base.
module amax10_qsys_sd_ram_loader #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 37500,
    parameter int LEN_W  = 18
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_start,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_abort,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] address,
    output logic [3:0]        byteenable,
    output logic              chipselect,
    output logic              write,
    output logic [31:0]       writedata,
    output logic              busy,
    output logic              done,
    output logic              wrapped
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_FINISH
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [ADDR_W-1:0] r_addr_cnt;
    logic [LEN_W-1:0]  r_remaining;
    logic [1:0]        r_lane;
    logic [31:0]       r_acc;
    logic [3:0]        r_lane_en;

    logic              r_in_ready;
    logic [ADDR_W-1:0] r_address;
    logic [3:0]        r_byteenable;
    logic              r_write;
    logic [31:0]       r_writedata;
    logic              r_busy;
    logic              r_done;
    logic              r_wrapped;

    logic              w_accept;
    logic              w_last_byte;
    logic              w_word_done;
    logic              w_start;
    logic              w_addr_wraps;
    logic [ADDR_W-1:0] w_addr_inc;
    logic [31:0]       w_acc_merged;
    logic [3:0]        w_en_merged;

    // in_ready is only ever high in BUSY, so it doubles as the acceptance qualifier.
    assign w_accept     = in_valid && r_in_ready;
    assign w_last_byte  = (r_remaining == LEN_W'(1));
    assign w_word_done  = w_accept && ((r_lane == 2'd3) || w_last_byte);
    assign w_start      = (r_state == S_IDLE) && cmd_start;
    assign w_addr_wraps = (r_addr_cnt == ADDR_W'(DEPTH - 1));
    assign w_addr_inc   = w_addr_wraps ? '0 : r_addr_cnt + ADDR_W'(1);
    assign w_acc_merged = r_acc | (32'(in_data) << {r_lane, 3'b000});
    assign w_en_merged  = r_lane_en | (4'b0001 << r_lane);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_start) begin
                    w_state_next = (cmd_len == '0) ? S_FINISH : S_BUSY;
                end
            end
            S_BUSY: begin
                if (cmd_abort) begin
                    w_state_next = S_IDLE;
                end else if (w_accept && w_last_byte) begin
                    w_state_next = S_FINISH;
                end
            end
            S_FINISH: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Output registers are loaded from the next state so every output is registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_in_ready   <= 1'b0;
            r_address    <= '0;
            r_byteenable <= '0;
            r_write      <= 1'b0;
            r_writedata  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_in_ready <= (w_state_next == S_BUSY);
            r_busy     <= (w_state_next != S_IDLE);
            r_done     <= (w_state_next == S_FINISH);
            r_write    <= w_word_done;
            if (w_word_done) begin
                r_address    <= r_addr_cnt;
                r_writedata  <= w_acc_merged;
                r_byteenable <= w_en_merged;
            end
        end
    end

    // A word completed in the abort cycle is still emitted; an incomplete one is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr_cnt  <= '0;
            r_remaining <= '0;
            r_lane      <= '0;
            r_acc       <= '0;
            r_lane_en   <= '0;
            r_wrapped   <= 1'b0;
        end else if (w_start) begin
            r_addr_cnt  <= cmd_base;
            r_remaining <= cmd_len;
            r_lane      <= '0;
            r_acc       <= '0;
            r_lane_en   <= '0;
            r_wrapped   <= 1'b0;
        end else if (w_word_done) begin
            r_addr_cnt  <= w_addr_inc;
            r_remaining <= r_remaining - LEN_W'(1);
            r_lane      <= '0;
            r_acc       <= '0;
            r_lane_en   <= '0;
            if (w_addr_wraps) begin
                r_wrapped <= 1'b1;
            end
        end else if ((r_state == S_BUSY) && cmd_abort) begin
            r_lane    <= '0;
            r_acc     <= '0;
            r_lane_en <= '0;
        end else if (w_accept) begin
            r_remaining <= r_remaining - LEN_W'(1);
            r_lane      <= r_lane + 2'd1;
            r_acc       <= w_acc_merged;
            r_lane_en   <= w_en_merged;
        end
    end

    assign in_ready   = r_in_ready;
    assign address    = r_address;
    assign byteenable = r_byteenable;
    assign chipselect = r_write;
    assign write      = r_write;
    assign writedata  = r_writedata;
    assign busy       = r_busy;
    assign done       = r_done;
    assign wrapped    = r_wrapped;

endmodule

// File: tb/tb_amax10_qsys_sd_ram_loader.sv
// Self-checking bench for amax10_qsys_sd_ram_loader: directed and random transfers
// compared against a word-level model of the expected RAM writes.
module tb_amax10_qsys_sd_ram_loader;

    localparam int ADDR_W = 16;
    localparam int DEPTH  = 37500;
    localparam int LEN_W  = 18;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              cmd_start;
    logic [ADDR_W-1:0] cmd_base;
    logic [LEN_W-1:0]  cmd_len;
    logic              cmd_abort;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] address;
    logic [3:0]        byteenable;
    logic              chipselect;
    logic              write;
    logic [31:0]       writedata;
    logic              busy;
    logic              done;
    logic              wrapped;

    amax10_qsys_sd_ram_loader #(
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH),
        .LEN_W (LEN_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_start (cmd_start),
        .cmd_base  (cmd_base),
        .cmd_len   (cmd_len),
        .cmd_abort (cmd_abort),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .address   (address),
        .byteenable(byteenable),
        .chipselect(chipselect),
        .write     (write),
        .writedata (writedata),
        .busy      (busy),
        .done      (done),
        .wrapped   (wrapped)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } wr_t;

    wr_t        wr_q[$];
    int         wr_cyc_q[$];
    wr_t        exp_q[$];
    logic [7:0] tx_q[$];
    bit         exp_wrap;

    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int last_acc = -1;
    int n_checks = 0;
    int n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Records every RAM write and done pulse as seen mid-cycle.
    always @(negedge clk) begin
        n_checks++;
        if (chipselect !== write) begin
            n_fail++;
            $display("[TB] FAIL cs_eq_write: chipselect=%b write=%b", chipselect, write);
        end
        if (write === 1'b1) begin
            wr_q.push_back({address, writedata, byteenable});
            wr_cyc_q.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation still running at time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic wr_t wr_at(input int i);
        if (i < wr_q.size()) return wr_q[i];
        return '1;
    endfunction

    function automatic int wr_cyc_at(input int i);
        if (i < wr_cyc_q.size()) return wr_cyc_q[i];
        return -100;
    endfunction

    // Word-level model: word w covers bytes 4w..4w+3 of the stream, lands at (base+w) mod DEPTH.
    function automatic void build_model(input int base, input int len);
        exp_q.delete();
        exp_wrap = 1'b0;
        for (int w = 0; w * 4 < len; w++) begin
            wr_t e;
            int  waddr;
            waddr = (base + w) % DEPTH;
            e.a  = 16'(waddr);
            e.d  = '0;
            e.be = '0;
            for (int b = 0; b < 4; b++) begin
                if (w * 4 + b < len) begin
                    e.d[8*b +: 8] = tx_q[w*4+b];
                    e.be[b] = 1'b1;
                end
            end
            if (waddr == DEPTH - 1) exp_wrap = 1'b1;
            exp_q.push_back(e);
        end
    endfunction

    task automatic clear_mon();
        wr_q.delete();
        wr_cyc_q.delete();
        done_cnt = 0;
        done_cyc = -1;
        last_acc = -1;
    endtask

    task automatic fill_random(input int n);
        tx_q.delete();
        for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
    endtask

    task automatic start_cmd(input logic [15:0] base, input logic [17:0] len);
        @(posedge clk); #1;
        cmd_start = 1'b1;
        cmd_base  = base;
        cmd_len   = len;
        @(posedge clk); #1;
        cmd_start = 1'b0;
    endtask

    task automatic send_bytes(input int n, input bit gaps, output bit ok);
        int idx;
        int guard;
        idx = 0;
        guard = 0;
        while (idx < n && guard < 400) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = tx_q[idx];
            @(negedge clk);
            if (in_valid && in_ready) begin
                last_acc = cyc;
                idx++;
            end
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        ok = (idx == n);
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({in_ready, address, byteenable, chipselect, write, writedata, busy, done, wrapped} !== 58'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_values: got %h want 0",
                     {in_ready, address, byteenable, chipselect, write, writedata, busy, done, wrapped});
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({in_ready, busy, done, write} !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL idle_after_reset: got %b want 0000", {in_ready, busy, done, write});
        end
    endtask

    task automatic test_full_words();
        bit ok;
        clear_mon();
        tx_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        start_cmd(16'h0010, 18'd8);
        n_checks++;
        if ({busy, in_ready} !== 2'b11) begin
            n_fail++;
            $display("[TB] FAIL full_busy_ready: got %b want 11", {busy, in_ready});
        end
        send_bytes(8, 1'b0, ok);
        repeat (4) @(negedge clk);
        n_checks++;
        if (!ok) begin n_fail++; $display("[TB] FAIL full_stream: got stalled want accepted"); end
        n_checks++;
        if (wr_q.size() != 2) begin n_fail++; $display("[TB] FAIL full_count: got %0d want 2", wr_q.size()); end
        n_checks++;
        if (wr_at(0) !== {16'h0010, 32'h44332211, 4'hF}) begin
            n_fail++;
            $display("[TB] FAIL full_word0: got %h want %h", wr_at(0), {16'h0010, 32'h44332211, 4'hF});
        end
        n_checks++;
        if (wr_at(1) !== {16'h0011, 32'h88776655, 4'hF}) begin
            n_fail++;
            $display("[TB] FAIL full_word1: got %h want %h", wr_at(1), {16'h0011, 32'h88776655, 4'hF});
        end
        n_checks++;
        if (done_cnt != 1) begin n_fail++; $display("[TB] FAIL full_done_count: got %0d want 1", done_cnt); end
        n_checks++;
        if (done_cyc != last_acc + 1) begin
            n_fail++;
            $display("[TB] FAIL full_done_latency: got cycle %0d want %0d", done_cyc, last_acc + 1);
        end
        n_checks++;
        if (wr_cyc_at(1) != done_cyc) begin
            n_fail++;
            $display("[TB] FAIL full_last_write_with_done: got cycle %0d want %0d", wr_cyc_at(1), done_cyc);
        end
        n_checks++;
        if (wr_cyc_at(1) - wr_cyc_at(0) != 4) begin
            n_fail++;
            $display("[TB] FAIL full_throughput: got spacing %0d want 4", wr_cyc_at(1) - wr_cyc_at(0));
        end
        n_checks++;
        if ({wrapped, busy} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL full_end_flags: got %b want 00", {wrapped, busy});
        end
    endtask

    task automatic test_partial_tail();
        bit ok;
        clear_mon();
        tx_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        start_cmd(16'h0000, 18'd6);
        send_bytes(6, 1'b0, ok);
        repeat (4) @(negedge clk);
        n_checks++;
        if (!ok || wr_q.size() != 2) begin
            n_fail++;
            $display("[TB] FAIL tail_count: got ok=%0d writes=%0d want ok=1 writes=2", ok, wr_q.size());
        end
        n_checks++;
        if (wr_at(0) !== {16'h0000, 32'h04030201, 4'hF}) begin
            n_fail++;
            $display("[TB] FAIL tail_word0: got %h want %h", wr_at(0), {16'h0000, 32'h04030201, 4'hF});
        end
        n_checks++;
        if (wr_at(1) !== {16'h0001, 32'h00000605, 4'h3}) begin
            n_fail++;
            $display("[TB] FAIL tail_word1: got %h want %h", wr_at(1), {16'h0001, 32'h00000605, 4'h3});
        end
        n_checks++;
        if (done_cnt != 1) begin n_fail++; $display("[TB] FAIL tail_done_count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_zero_length();
        clear_mon();
        start_cmd(16'h0123, 18'd0);
        n_checks++;
        if ({done, busy, write} !== 3'b110) begin
            n_fail++;
            $display("[TB] FAIL zero_finish: got done,busy,write=%b want 110", {done, busy, write});
        end
        @(posedge clk); #1;
        n_checks++;
        if ({done, busy} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL zero_back_idle: got done,busy=%b want 00", {done, busy});
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (wr_q.size() != 0 || done_cnt != 1) begin
            n_fail++;
            $display("[TB] FAIL zero_writes: got writes=%0d done=%0d want 0 and 1", wr_q.size(), done_cnt);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        clear_mon();
        fill_random(8);
        build_model(DEPTH - 1, 8);
        start_cmd(16'(DEPTH - 1), 18'd8);
        send_bytes(8, 1'b0, ok);
        repeat (4) @(negedge clk);
        n_checks++;
        if (!ok || wr_q.size() != 2) begin
            n_fail++;
            $display("[TB] FAIL wrap_count: got ok=%0d writes=%0d want ok=1 writes=2", ok, wr_q.size());
        end
        n_checks++;
        if (wr_at(0).a !== 16'd37499 || wr_at(1).a !== 16'd0) begin
            n_fail++;
            $display("[TB] FAIL wrap_addresses: got %0d,%0d want 37499,0", wr_at(0).a, wr_at(1).a);
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            n_checks++;
            if (wr_at(k) !== exp_q[k]) begin
                n_fail++;
                $display("[TB] FAIL wrap_word%0d: got %h want %h", k, wr_at(k), exp_q[k]);
            end
        end
        n_checks++;
        if (wrapped !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_flag: got %b want 1", wrapped); end
    endtask

    task automatic test_gaps();
        bit ok;
        int base;
        clear_mon();
        fill_random(12);
        base = $urandom_range(0, DEPTH - 10);
        build_model(base, 12);
        start_cmd(16'(base), 18'd12);
        send_bytes(12, 1'b1, ok);
        repeat (4) @(negedge clk);
        n_checks++;
        if (!ok || wr_q.size() != 3) begin
            n_fail++;
            $display("[TB] FAIL gaps_count: got ok=%0d writes=%0d want ok=1 writes=3", ok, wr_q.size());
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            n_checks++;
            if (wr_at(k) !== exp_q[k]) begin
                n_fail++;
                $display("[TB] FAIL gaps_word%0d: got %h want %h", k, wr_at(k), exp_q[k]);
            end
        end
        n_checks++;
        if (done_cnt != 1 || done_cyc != last_acc + 1) begin
            n_fail++;
            $display("[TB] FAIL gaps_done: got count=%0d cycle=%0d want 1 at %0d", done_cnt, done_cyc, last_acc + 1);
        end
    endtask

    task automatic test_abort();
        bit  ok;
        wr_t exp0;
        clear_mon();
        fill_random(12);
        exp0 = {16'h0040, tx_q[3], tx_q[2], tx_q[1], tx_q[0], 4'hF};
        start_cmd(16'h0040, 18'd12);
        // a second start while busy must not move the base or length
        cmd_start = 1'b1;
        cmd_base  = 16'h0500;
        cmd_len   = 18'd3;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        send_bytes(5, 1'b0, ok);
        cmd_abort = 1'b1;
        @(posedge clk); #1;
        cmd_abort = 1'b0;
        n_checks++;
        if ({busy, in_ready} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL abort_idle: got busy,in_ready=%b want 00", {busy, in_ready});
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (!ok || wr_q.size() != 1) begin
            n_fail++;
            $display("[TB] FAIL abort_count: got ok=%0d writes=%0d want ok=1 writes=1", ok, wr_q.size());
        end
        n_checks++;
        if (wr_at(0) !== exp0) begin
            n_fail++;
            $display("[TB] FAIL abort_word0: got %h want %h", wr_at(0), exp0);
        end
        n_checks++;
        if (done_cnt != 0) begin n_fail++; $display("[TB] FAIL abort_no_done: got %0d want 0", done_cnt); end
    endtask

    task automatic test_reset_mid();
        bit  ok;
        wr_t exp0;
        clear_mon();
        fill_random(4);
        start_cmd(16'h0100, 18'd4);
        send_bytes(2, 1'b0, ok);
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, address, byteenable, chipselect, write, writedata, busy, done, wrapped} !== 58'd0) begin
            n_fail++;
            $display("[TB] FAIL midreset_outputs: got %h want 0",
                     {in_ready, address, byteenable, chipselect, write, writedata, busy, done, wrapped});
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (wr_q.size() != 0 || done_cnt != 0) begin
            n_fail++;
            $display("[TB] FAIL midreset_quiet: got writes=%0d done=%0d want 0 and 0", wr_q.size(), done_cnt);
        end
        clear_mon();
        fill_random(4);
        exp0 = {16'h0020, tx_q[3], tx_q[2], tx_q[1], tx_q[0], 4'hF};
        start_cmd(16'h0020, 18'd4);
        send_bytes(4, 1'b0, ok);
        repeat (4) @(negedge clk);
        n_checks++;
        if (!ok || wr_q.size() != 1 || wr_at(0) !== exp0 || done_cnt != 1) begin
            n_fail++;
            $display("[TB] FAIL midreset_restart: got ok=%0d writes=%0d word=%h done=%0d want 1,1,%h,1",
                     ok, wr_q.size(), wr_at(0), done_cnt, exp0);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int base;
        int len;
        bit gaps;
        for (int t = 0; t < 8; t++) begin
            clear_mon();
            base = (t % 2 == 1) ? DEPTH - 1 - int'($urandom_range(0, 4)) : int'($urandom_range(0, DEPTH - 1));
            len  = $urandom_range(1, 21);
            gaps = 1'($urandom_range(0, 1));
            fill_random(len);
            build_model(base, len);
            start_cmd(16'(base), 18'(len));
            send_bytes(len, gaps, ok);
            repeat (3) @(negedge clk);
            n_checks++;
            if (!ok || wr_q.size() != exp_q.size()) begin
                n_fail++;
                $display("[TB] FAIL b2b%0d_count: got ok=%0d writes=%0d want ok=1 writes=%0d",
                         t, ok, wr_q.size(), exp_q.size());
            end
            for (int k = 0; k < exp_q.size(); k++) begin
                n_checks++;
                if (wr_at(k) !== exp_q[k]) begin
                    n_fail++;
                    $display("[TB] FAIL b2b%0d_word%0d: got %h want %h", t, k, wr_at(k), exp_q[k]);
                end
            end
            n_checks++;
            if (done_cnt != 1 || wrapped !== exp_wrap) begin
                n_fail++;
                $display("[TB] FAIL b2b%0d_flags: got done=%0d wrapped=%b want 1 and %b",
                         t, done_cnt, wrapped, exp_wrap);
            end
        end
    endtask

    initial begin
        cmd_start = 1'b0;
        cmd_base  = '0;
        cmd_len   = '0;
        cmd_abort = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        test_reset();
        test_full_words();
        test_partial_tail();
        test_zero_length();
        test_wrap();
        test_gaps();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
